alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 236 +++++++++++++++++++++++
 tb/tb_alu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
`timescale 1ns/1ps
// Keypad BCD calculator: 10-digit signed-magnitude entry/accumulator with sticky overflow flags.
// Optional macro ALU_INPUT_EDGE_EN: accept keys only on idle->active transitions (default: level, held key repeats).
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  digit,
   input  logic [1:0]  operation,
   input  logic        clear_ALU,
   output logic [39:0] AUX,
   output logic        sgn_AUX,
   output logic        full_AUX,
   output logic        full_ACC
);

   typedef enum logic [1:0] {EMPTY, DIGITS, RESULT, OVF} mode_t;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_MINUS = 2'b10;
   localparam logic [1:0] OP_EQ    = 2'b11;

   mode_t       mode, mode_nxt;
   logic [39:0] acc, acc_nxt, aux_nxt;
   logic        acc_sgn, acc_sgn_nxt, sgn_nxt;
   logic        pend, pend_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        full_aux_nxt, full_acc_nxt;
   logic        dig_key, op_key, dig_evt, op_evt;
   logic        do_arith, do_eq;

   logic        b_sgn, res_sgn, res_ovf;
   logic [40:0] sum;
   logic [39:0] res_mag;

   function automatic logic [40:0] bcd_add(input logic [39:0] a, input logic [39:0] b);
      logic [4:0]  s;
      logic        c;
      logic [39:0] r;
      c = 1'b0;
      r = '0;
      for (int i = 0; i < 10; i++) begin
         s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, c};
         if (s > 5'd9) begin
            s = s - 5'd10;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[i*4 +: 4] = s[3:0];
      end
      return {c, r};
   endfunction

   // Caller guarantees a >= b, so the final borrow is always zero.
   function automatic logic [39:0] bcd_sub(input logic [39:0] a, input logic [39:0] b);
      logic [4:0]  s;
      logic        br;
      logic [39:0] r;
      br = 1'b0;
      r  = '0;
      for (int i = 0; i < 10; i++) begin
         s = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'b0, br};
         if (s[4]) begin
            s  = s + 5'd10;
            br = 1'b1;
         end else begin
            br = 1'b0;
         end
         r[i*4 +: 4] = s[3:0];
      end
      return r;
   endfunction

   assign dig_key = (digit <= 4'd9);
   assign op_key  = (operation != OP_NONE);

`ifdef ALU_INPUT_EDGE_EN
   logic dig_hist_idle, op_hist_idle;
   assign dig_evt = dig_key && dig_hist_idle;
   assign op_evt  = op_key && op_hist_idle;

   // Reset arms the history as "key held" so a key held through reset is not a fresh press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_hist_idle <= 1'b0;
         op_hist_idle  <= 1'b0;
      end else if (clear_ALU) begin
         dig_hist_idle <= 1'b1;
         op_hist_idle  <= 1'b1;
      end else begin
         dig_hist_idle <= !dig_key;
         op_hist_idle  <= !op_key;
      end
   end
`else
   assign dig_evt = dig_key;
   assign op_evt  = op_key;
`endif

   // Signed-magnitude combine of ACC with the entry under the pending operation.
   always_comb begin
      b_sgn   = sgn_AUX ^ pend;
      sum     = bcd_add(acc, AUX);
      res_ovf = 1'b0;
      if (acc_sgn == b_sgn) begin
         res_mag = sum[39:0];
         res_ovf = sum[40];
         res_sgn = acc_sgn;
      end else if (acc >= AUX) begin
         res_mag = bcd_sub(acc, AUX);
         res_sgn = acc_sgn;
      end else begin
         res_mag = bcd_sub(AUX, acc);
         res_sgn = b_sgn;
      end
      if (res_mag == 40'd0)
         res_sgn = 1'b0;
   end

   always_comb begin
      mode_nxt     = mode;
      acc_nxt      = acc;
      acc_sgn_nxt  = acc_sgn;
      aux_nxt      = AUX;
      sgn_nxt      = sgn_AUX;
      pend_nxt     = pend;
      cnt_nxt      = cnt;
      full_aux_nxt = full_AUX;
      full_acc_nxt = full_ACC;
      do_arith     = 1'b0;
      do_eq        = (operation == OP_EQ);

      if (op_evt) begin
         case (mode)
            EMPTY: begin
               if (do_eq) do_arith = 1'b1;
               else       sgn_nxt  = (operation == OP_MINUS);
            end
            DIGITS: do_arith = 1'b1;
            RESULT: begin
               if (!do_eq) begin
                  pend_nxt = (operation == OP_MINUS);
                  aux_nxt  = '0;
                  sgn_nxt  = 1'b0;
                  cnt_nxt  = '0;
                  mode_nxt = EMPTY;
               end
            end
            default: ;
         endcase
      end else if (dig_evt) begin
         case (mode)
            EMPTY, DIGITS: begin
               if (cnt < 4'd10) begin
                  aux_nxt  = {AUX[35:0], digit};
                  mode_nxt = DIGITS;
                  if (!(AUX == 40'd0 && digit == 4'd0))
                     cnt_nxt = cnt + 4'd1;
               end else begin
                  full_aux_nxt = 1'b1;
               end
            end
            RESULT: begin
               acc_nxt     = '0;
               acc_sgn_nxt = 1'b0;
               aux_nxt     = {36'd0, digit};
               sgn_nxt     = 1'b0;
               cnt_nxt     = (digit != 4'd0) ? 4'd1 : 4'd0;
               mode_nxt    = DIGITS;
            end
            default: ;
         endcase
      end

      if (do_arith) begin
         acc_nxt     = res_mag;
         acc_sgn_nxt = res_sgn;
         if (res_ovf) begin
            full_acc_nxt = 1'b1;
            aux_nxt      = res_mag;
            sgn_nxt      = res_sgn;
            mode_nxt     = OVF;
         end else if (do_eq) begin
            aux_nxt  = res_mag;
            sgn_nxt  = res_sgn;
            pend_nxt = 1'b0;
            cnt_nxt  = '0;
            mode_nxt = RESULT;
         end else begin
            pend_nxt     = (operation == OP_MINUS);
            aux_nxt      = '0;
            sgn_nxt      = 1'b0;
            cnt_nxt      = '0;
            full_aux_nxt = 1'b0;
            mode_nxt     = EMPTY;
         end
      end

      if (clear_ALU) begin
         mode_nxt     = EMPTY;
         acc_nxt      = '0;
         acc_sgn_nxt  = 1'b0;
         aux_nxt      = '0;
         sgn_nxt      = 1'b0;
         pend_nxt     = 1'b0;
         cnt_nxt      = '0;
         full_aux_nxt = 1'b0;
         full_acc_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode     <= EMPTY;
         acc      <= '0;
         acc_sgn  <= 1'b0;
         AUX      <= '0;
         sgn_AUX  <= 1'b0;
         pend     <= 1'b0;
         cnt      <= '0;
         full_AUX <= 1'b0;
         full_ACC <= 1'b0;
      end else begin
         mode     <= mode_nxt;
         acc      <= acc_nxt;
         acc_sgn  <= acc_sgn_nxt;
         AUX      <= aux_nxt;
         sgn_AUX  <= sgn_nxt;
         pend     <= pend_nxt;
         cnt      <= cnt_nxt;
         full_AUX <= full_aux_nxt;
         full_ACC <= full_acc_nxt;
      end
   end

endmodule

// File: tb/tb_alu.sv
`timescale 1ns/1ps
// Directed bench for the keypad BCD ALU; expectations are hand-computed decimal results.
module tb_alu;

   localparam logic [1:0] PLUS  = 2'b01;
   localparam logic [1:0] MINUS = 2'b10;
   localparam logic [1:0] EQ    = 2'b11;
   localparam logic [3:0] IDLE  = 4'hD;

   logic        clk, rst_n, clear_ALU;
   logic [3:0]  digit;
   logic [1:0]  operation;
   logic [39:0] AUX;
   logic        sgn_AUX, full_AUX, full_ACC;

   int checks = 0;
   int failures = 0;

   alu dut (
      .clk(clk), .rst_n(rst_n), .digit(digit), .operation(operation),
      .clear_ALU(clear_ALU), .AUX(AUX), .sgn_AUX(sgn_AUX),
      .full_AUX(full_AUX), .full_ACC(full_ACC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic key(input logic [3:0] d);
      @(negedge clk); digit = d;
      @(negedge clk); digit = IDLE;
   endtask

   task automatic op(input logic [1:0] o);
      @(negedge clk); operation = o;
      @(negedge clk); operation = 2'b00;
   endtask

   task automatic clr();
      @(negedge clk); clear_ALU = 1'b1;
      @(negedge clk); clear_ALU = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({AUX, sgn_AUX, full_AUX, full_ACC} !== 43'd0) begin
         failures++;
         $display("FAIL reset_outputs got %h %b%b%b want 0", AUX, sgn_AUX, full_AUX, full_ACC);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_add();
      clr(); key(4); key(6); op(PLUS); key(7); key(0); op(EQ);
      checks++;
      if ({AUX, sgn_AUX, full_AUX, full_ACC} !== {40'h116, 3'b000}) begin
         failures++;
         $display("FAIL add_46_70 got %h sgn=%b fa=%b fc=%b want 116 0 0 0", AUX, sgn_AUX, full_AUX, full_ACC);
      end
   endtask

   task automatic test_result_mode();
      op(EQ);
      checks++;
      if (AUX !== 40'h116) begin
         failures++;
         $display("FAIL eq_in_result got %h want 116", AUX);
      end
      key(3);
      checks++;
      if (AUX !== 40'h3) begin
         failures++;
         $display("FAIL digit_after_result got %h want 3", AUX);
      end
      op(EQ);
      checks++;
      if ({AUX, sgn_AUX} !== {40'h3, 1'b0}) begin
         failures++;
         $display("FAIL new_entry_eq got %h sgn=%b want 3 0", AUX, sgn_AUX);
      end
   endtask

   task automatic test_sub_neg();
      clr(); op(MINUS); key(8); key(8); op(MINUS); key(2); key(1); key(2); op(EQ);
      checks++;
      if ({AUX, sgn_AUX} !== {40'h300, 1'b1}) begin
         failures++;
         $display("FAIL neg88_minus212 got %h sgn=%b want 300 1", AUX, sgn_AUX);
      end
   endtask

   task automatic test_sub_cross();
      clr(); key(1); key(6); op(MINUS); key(1); key(8); key(5); op(EQ);
      checks++;
      if ({AUX, sgn_AUX} !== {40'h169, 1'b1}) begin
         failures++;
         $display("FAIL 16_minus185 got %h sgn=%b want 169 1", AUX, sgn_AUX);
      end
   endtask

   task automatic test_sign_entry();
      clr(); op(MINUS); key(9); op(PLUS); key(5); key(6); key(4); op(EQ);
      checks++;
      if ({AUX, sgn_AUX} !== {40'h555, 1'b0}) begin
         failures++;
         $display("FAIL neg9_plus564 got %h sgn=%b want 555 0", AUX, sgn_AUX);
      end
   endtask

   task automatic test_neg_zero();
      clr(); key(5); op(MINUS); key(5); op(EQ);
      checks++;
      if ({AUX, sgn_AUX} !== 41'd0) begin
         failures++;
         $display("FAIL neg_zero got %h sgn=%b want 0 0", AUX, sgn_AUX);
      end
   endtask

   task automatic test_leading_zero();
      logic [3:0] seq [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1};
      clr(); key(0); key(0); key(0);
      foreach (seq[i]) key(seq[i]);
      checks++;
      if ({AUX, full_AUX} !== {40'h1234567891, 1'b0}) begin
         failures++;
         $display("FAIL leading_zero got %h fa=%b want 1234567891 0", AUX, full_AUX);
      end
      key(2);
      checks++;
      if ({AUX, full_AUX} !== {40'h1234567891, 1'b1}) begin
         failures++;
         $display("FAIL entry_full got %h fa=%b want 1234567891 1", AUX, full_AUX);
      end
   endtask

   task automatic test_overflow();
      clr();
      for (int i = 0; i < 10; i++) key(9);
      key(4);
      checks++;
      if ({AUX, full_AUX, full_ACC} !== {40'h9999999999, 2'b10}) begin
         failures++;
         $display("FAIL ten_nines got %h fa=%b fc=%b want 9999999999 1 0", AUX, full_AUX, full_ACC);
      end
      op(PLUS);
      checks++;
      if ({AUX, full_AUX} !== 41'd0) begin
         failures++;
         $display("FAIL plus_clears_entry got %h fa=%b want 0 0", AUX, full_AUX);
      end
      key(9); op(EQ);
      checks++;
      if ({AUX, full_ACC} !== {40'h0000000008, 1'b1}) begin
         failures++;
         $display("FAIL acc_overflow got %h fc=%b want 0000000008 1", AUX, full_ACC);
      end
      key(5); op(PLUS); key(1);
      checks++;
      if ({AUX, full_ACC} !== {40'h0000000008, 1'b1}) begin
         failures++;
         $display("FAIL ovf_ignores got %h fc=%b want 0000000008 1", AUX, full_ACC);
      end
      clr();
      checks++;
      if ({AUX, sgn_AUX, full_AUX, full_ACC} !== 43'd0) begin
         failures++;
         $display("FAIL clear_after_ovf got %h %b%b%b want 0", AUX, sgn_AUX, full_AUX, full_ACC);
      end
   endtask

   task automatic test_same_cycle();
      clr(); key(4);
      @(negedge clk); digit = 4'd7; operation = PLUS;
      @(negedge clk); digit = IDLE; operation = 2'b00;
      checks++;
      if (AUX !== 40'h0) begin
         failures++;
         $display("FAIL op_beats_digit got %h want 0", AUX);
      end
      key(1); op(EQ);
      checks++;
      if (AUX !== 40'h5) begin
         failures++;
         $display("FAIL op_beats_digit_sum got %h want 5", AUX);
      end
   endtask

   task automatic test_hold();
      logic [39:0] exp;
`ifdef ALU_INPUT_EDGE_EN
      exp = 40'h3;
`else
      exp = 40'h333;
`endif
      clr();
      @(negedge clk); digit = 4'd3;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); digit = IDLE;
      checks++;
      if (AUX !== exp) begin
         failures++;
         $display("FAIL held_key got %h want %h", AUX, exp);
      end
   endtask

   task automatic test_reset_mid();
      logic [39:0] exp_hold, exp_sum;
`ifdef ALU_INPUT_EDGE_EN
      exp_hold = 40'h0;
      exp_sum  = 40'h7;
`else
      exp_hold = 40'h5;
      exp_sum  = 40'h57;
`endif
      clr(); key(1); key(2);
      @(negedge clk); #2;
      rst_n = 1'b0; digit = 4'd5;
      #1;
      checks++;
      if ({AUX, sgn_AUX, full_AUX, full_ACC} !== 43'd0) begin
         failures++;
         $display("FAIL async_reset got %h %b%b%b want 0", AUX, sgn_AUX, full_AUX, full_ACC);
      end
      @(posedge clk); #2; rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (AUX !== 40'h0) begin
         failures++;
         $display("FAIL before_first_edge got %h want 0", AUX);
      end
      @(negedge clk); digit = IDLE;
      checks++;
      if (AUX !== exp_hold) begin
         failures++;
         $display("FAIL held_through_reset got %h want %h", AUX, exp_hold);
      end
      key(7); op(EQ);
      checks++;
      if (AUX !== exp_sum) begin
         failures++;
         $display("FAIL after_reset_sum got %h want %h", AUX, exp_sum);
      end
   endtask

   initial begin
      rst_n = 1'b0; digit = IDLE; operation = 2'b00; clear_ALU = 1'b0;
      test_reset();
      test_add();
      test_result_mode();
      test_sub_neg();
      test_sub_cross();
      test_sign_entry();
      test_neg_zero();
      test_leading_zero();
      test_overflow();
      test_same_cycle();
      test_hold();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
